aes_req_arbiter: RTL and testbench

- Shares one fixed-latency, non-stallable pipelined AES-128 cipher core among NUM_REQ requesters, for example per-tile DCP config ports.
- Arbitrates requests round-robin and issues them to the core.
- Tags each issued operation with its requester index and buffers core results in a response FIFO.
- Outstanding operations are credit-limited, so a result is never lost when the response consumer stalls.

---
 rtl/aes_req_arbiter_if.sv | 34 +++
 rtl/aes_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_aes_req_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_req_arbiter_if.sv
// Bundles the requester, AES-core and response signals of aes_req_arbiter.
// The arbiter connects through the slave modport; requesters, core and consumer use master.
interface aes_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  // Handshakes: a transfer happens in a cycle where valid && ready are both high
  // at the rising clock edge. A raised valid holds its data stable until that
  // transfer. The core path (aes_valid_in/aes_valid_out) is a pulse with no ready.
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_key;
  logic [NUM_REQ*128-1:0] req_plain;
  logic                   aes_valid_in;
  logic [127:0]           aes_key;
  logic [127:0]           aes_plain;
  logic                   aes_valid_out;
  logic [127:0]           aes_cipher;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IDW-1:0]         resp_id;
  logic [127:0]           resp_data;

  modport slave (
    input  req_valid, req_key, req_plain, aes_valid_out, aes_cipher, resp_ready,
    output req_ready, aes_valid_in, aes_key, aes_plain, resp_valid, resp_id, resp_data
  );

  modport master (
    output req_valid, req_key, req_plain, aes_valid_out, aes_cipher, resp_ready,
    input  req_ready, aes_valid_in, aes_key, aes_plain, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/aes_req_arbiter.sv
// Round-robin, credit-limited sharing of one fixed-latency pipelined AES-128 core.
// Optional watchdog on stalled core results: define AES_ARB_WATCHDOG_EN.
module aes_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_req_arbiter_if.slave bus,
  output logic             idle,
  output logic             err_spurious,
  output logic             err_timeout
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int AW  = $clog2(MAX_OUT);
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]  MAX_CRED = CW'(MAX_OUT);
  localparam logic [IDW:0]   NR       = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   scan_idx;
  logic [IDW:0]     scan_sum;
  logic             grant_found;
  logic             accept;
  logic             pop_resp;
  logic             tag_empty;
  logic             tag_pop;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    tag_cnt;
  logic [CW-1:0]    resp_cnt;
  logic [AW-1:0]    tag_wr;
  logic [AW-1:0]    tag_rd;
  logic [AW-1:0]    resp_wr;
  logic [AW-1:0]    resp_rd;
  logic [IDW-1:0]   tag_mem [MAX_OUT];
  logic [IDW+127:0] resp_mem [MAX_OUT];
  logic [IDW+127:0] resp_head;
  logic [127:0]     sel_key;
  logic [127:0]     sel_plain;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (scan_sum >= NR) scan_sum = scan_sum - NR;
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_key   = '0;
    sel_plain = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_key   = bus.req_key[i*128 +: 128];
        sel_plain = bus.req_plain[i*128 +: 128];
      end
    end
  end

  assign accept    = grant_found && (credits < MAX_CRED);
  assign tag_empty = (tag_cnt == '0);
  assign tag_pop   = bus.aes_valid_out && !tag_empty;
  assign pop_resp  = bus.resp_valid && bus.resp_ready;
  assign idle      = (credits == '0);

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant_idx] = 1'b1;
  end

  // Head entry is masked while empty so the outputs read zero out of reset.
  assign resp_head      = resp_mem[resp_rd];
  assign bus.resp_valid = (resp_cnt != '0);
  assign bus.resp_id    = bus.resp_valid ? resp_head[IDW+127:128] : '0;
  assign bus.resp_data  = bus.resp_valid ? resp_head[127:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr           <= '0;
      credits          <= '0;
      bus.aes_valid_in <= 1'b0;
      bus.aes_key      <= '0;
      bus.aes_plain    <= '0;
      err_spurious     <= 1'b0;
      tag_wr           <= '0;
      tag_rd           <= '0;
      tag_cnt          <= '0;
      resp_wr          <= '0;
      resp_rd          <= '0;
      resp_cnt         <= '0;
    end else begin
      bus.aes_valid_in <= accept;
      if (accept) begin
        bus.aes_key   <= sel_key;
        bus.aes_plain <= sel_plain;
        rr_ptr        <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDW'(1);
        tag_wr        <= tag_wr + AW'(1);
      end
      if (accept && !pop_resp) credits <= credits + CW'(1);
      else if (!accept && pop_resp) credits <= credits - CW'(1);
      if (tag_pop) begin
        tag_rd  <= tag_rd + AW'(1);
        resp_wr <= resp_wr + AW'(1);
      end
      if (pop_resp) resp_rd <= resp_rd + AW'(1);
      tag_cnt  <= tag_cnt + CW'(accept) - CW'(tag_pop);
      resp_cnt <= resp_cnt + CW'(tag_pop) - CW'(pop_resp);
      // A core result with no outstanding tag has no owner: drop it and flag.
      if (bus.aes_valid_out && tag_empty) err_spurious <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= grant_idx;
    if (tag_pop) resp_mem[resp_wr] <= {tag_mem[tag_rd], bus.aes_cipher};
  end

`ifdef AES_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  // Counts cycles an issued op waits for the core; saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (!tag_empty && !bus.aes_valid_out) begin
      if (wd_cnt != WW'(TIMEOUT)) wd_cnt <= wd_cnt + WW'(1);
      if (wd_cnt == WW'(TIMEOUT - 1)) err_timeout <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  // Watchdog absent: the flag is constant zero.
  assign err_timeout = 1'b0 & (TIMEOUT != 0);
`endif
endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized bench for aes_req_arbiter with a queue-based reference model and a
// fixed-latency core stand-in that knows the FIPS-197 example vector.
module tb_aes_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MAX_OUT = 16;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 6;
  localparam int IDW     = 2;
  localparam int W       = IDW + 128;
  localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C0 = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic idle, err_spurious, err_timeout;
  aes_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  aes_req_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MAX_OUT(MAX_OUT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .idle        (idle),
    .err_spurious(err_spurious),
    .err_timeout (err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core stand-in: the real cipher for the known vector, a cheap mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == K0 && p == P0) return C0;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  // ---------------- core model ----------------
  logic           inject = 1'b0;
  logic           drop   = 1'b0;
  logic [LAT-1:0] pv;
  logic [127:0]   pc [LAT];

  always @(posedge clk) begin
    if (!rst_n) pv <= '0;
    else pv <= {pv[LAT-2:0], bus.aes_valid_in & ~drop};
    pc[0] <= core_fn(bus.aes_key, bus.aes_plain);
    for (int i = 1; i < LAT; i++) pc[i] <= pc[i-1];
  end
  assign bus.aes_valid_out = pv[LAT-1] | inject;
  assign bus.aes_cipher    = pc[LAT-1];

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0]       exp_q[$];
  logic [W-1:0]       fly_q[$];
  int                 m_rr, m_cred, g, idx;
  bit                 m_iss, m_spur, do_pop;
  logic [127:0]       m_key, m_plain, sk, sp;
  logic [NUM_REQ-1:0] er;
  logic [W-1:0]       hd;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_rr = 0; m_cred = 0; m_iss = 0; m_spur = 0;
      m_key = '0; m_plain = '0;
      exp_q.delete();
      fly_q.delete();
    end else begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_rr + k) % NUM_REQ;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
      er = '0;
      if (g >= 0 && m_cred < MAX_OUT) er[g] = 1'b1;
      hd = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("req_ready", bus.req_ready, er);
      chk("resp_valid", bus.resp_valid, exp_q.size() != 0);
      chk("resp_id", bus.resp_id, hd[W-1:128]);
      chk("resp_data", bus.resp_data, hd[127:0]);
      chk("idle", idle, m_cred == 0);
      chk("aes_valid_in", bus.aes_valid_in, m_iss);
      chk("aes_key", bus.aes_key, m_key);
      chk("aes_plain", bus.aes_plain, m_plain);
      chk("err_spurious", err_spurious, m_spur);
`ifndef AES_ARB_WATCHDOG_EN
      chk("err_timeout", err_timeout, 1'b0);
`endif
      // State for the coming clock edge.
      do_pop = (exp_q.size() != 0) && bus.resp_ready;
      if (bus.aes_valid_out) begin
        if (fly_q.size() != 0) exp_q.push_back(fly_q.pop_front());
        else m_spur = 1'b1;
      end
      if (do_pop) begin
        void'(exp_q.pop_front());
        m_cred--;
      end
      m_iss = (er != '0);
      if (er != '0) begin
        sk = bus.req_key[g*128 +: 128];
        sp = bus.req_plain[g*128 +: 128];
        m_key = sk;
        m_plain = sp;
        fly_q.push_back({IDW'(g), core_fn(sk, sp)});
        m_rr = (g + 1) % NUM_REQ;
        m_cred++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_slice(input int i);
    bus.req_key[i*128 +: 128]   = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.req_plain[i*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic run_phase(input int cycles, input int pv_pct, input int pr_pct, input bit rot);
    logic [NUM_REQ-1:0] a;
    a = '0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (a[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < pv_pct);
          rand_slice(i);
        end
      end
      bus.resp_ready = ($urandom_range(0, 99) < pr_pct);
      @(negedge clk);
      a = bus.req_valid & bus.req_ready;
      if (rot) chk("rotation", bus.req_ready, 4'b0001 << (k % 4));
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = idle;
    end
    chk("drain_idle", idle, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int n;
  int wk;
  bit hit;
  bit got;

  initial begin
    bus.req_valid  = '0;
    bus.req_key    = '0;
    bus.req_plain  = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", idle, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_aes_valid_in", bus.aes_valid_in, 1'b0);
    chk("rst_aes_key", bus.aes_key, 128'h0);
    chk("rst_err_spurious", err_spurious, 1'b0);

    // Single op with the FIPS-197 vector on requester 2.
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    bus.req_key[2*128 +: 128]   = K0;
    bus.req_plain[2*128 +: 128] = P0;
    @(negedge clk);
    chk("single_ready", bus.req_ready, 4'b0100);
    chk("single_no_issue_yet", bus.aes_valid_in, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("single_issue", bus.aes_valid_in, 1'b1);
    chk("single_key", bus.aes_key, K0);
    chk("single_plain", bus.aes_plain, P0);
    @(negedge clk);
    chk("single_pulse_end", bus.aes_valid_in, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.resp_valid;
    end
    chk("single_resp_seen", got, 1'b1);
    chk("single_resp_id", bus.resp_id, 2'd2);
    chk("single_resp_data", bus.resp_data, C0);
    @(negedge clk);
    chk("single_idle_after_pop", idle, 1'b1);

    // All requesters valid, consumer always ready: strict rotation.
    do_reset();
    run_phase(40, 100, 100, 1'b1);
    drain();

    // Random traffic and back-pressure.
    run_phase(400, 60, 50, 1'b0);
    drain();

    // Credit limit with a stalled consumer.
    do_reset();
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    rand_slice(0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.req_valid[0] && bus.req_ready[0]) n++;
    end
    chk("credit_limit_accepts", n, 16);
    chk("full_ready", bus.req_ready, 4'b0000);
    chk("full_resp_valid", bus.resp_valid, 1'b1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    if (bus.req_valid[0] && bus.req_ready[0]) n++;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.req_valid[0] && bus.req_ready[0]) n++;
    end
    chk("one_pop_one_accept", n, 1);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("sim_pre_full", bus.req_ready, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      chk("sim_accept_pop_hold", bus.req_ready, 4'b0001);
    end
    drain();

    // Spurious core result, then reset clears everything.
    do_reset();
    @(posedge clk); #1;
    bus.req_valid = 4'b0010;
    rand_slice(1);
    drain();
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    chk("spurious_flag", err_spurious, 1'b1);
    chk("spurious_no_resp", bus.resp_valid, 1'b0);
    do_reset();
    @(negedge clk);
    chk("reset_clears_spurious", err_spurious, 1'b0);
    chk("reset_idle", idle, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 4'b1111;
    rand_slice(0);
    @(negedge clk);
    chk("reset_rr_ptr", bus.req_ready, 4'b0001);
    drain();

    // Core never answers: watchdog behaviour.
    do_reset();
    drop = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    rand_slice(0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wk = 0;
    hit = 1'b0;
    while (wk < 2 * TIMEOUT && !hit) begin
      @(negedge clk);
      if (err_timeout) hit = 1'b1;
      else wk++;
    end
`ifdef AES_ARB_WATCHDOG_EN
    chk("watchdog_latency", wk, TIMEOUT);
`else
    chk("no_watchdog", err_timeout, 1'b0);
`endif
    drop = 1'b0;
    do_reset();
    @(negedge clk);
    chk("final_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, limit 500000");
    $fatal(1, "timeout");
  end
endmodule
